// File: rtl/csi2tx_payload_serializer.sv
// CSI-2 TX payload serializer: 32-bit buffer words to an LSB-first byte stream.
// Macro CSI2TX_PAYLOAD_CRC_EN appends the CSI-2 CRC-16 (two bytes) to each packet.
module csi2tx_payload_serializer #(
    parameter logic [15:0] CRC_SEED = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pkt_start,
    input  logic [15:0] word_count,
    output logic        busy,
    output logic        buf_rden,
    input  logic [31:0] buf_rddata,
    input  logic        buf_rddata_vld,
    input  logic        buf_empty,
    output logic [7:0]  byte_data,
    output logic        byte_vld,
    input  logic        byte_rdy,
    output logic        byte_last,
    output logic [15:0] crc_out
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        SHIFT
`ifdef CSI2TX_PAYLOAD_CRC_EN
        ,
        CRC_LO,
        CRC_HI
`endif
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_cnt;
    logic [31:0] r_shift;
    logic [1:0]  r_idx;
    logic        w_start;
    logic        w_load;
    logic        w_adv;

    assign w_start = (r_state == IDLE) && pkt_start;
    assign w_load  = (r_state == WAIT) && buf_rddata_vld;
    assign w_adv   = (r_state == SHIFT) && byte_rdy;

`ifdef CSI2TX_PAYLOAD_CRC_EN
    logic [15:0] r_crc;
    logic [15:0] r_crc_out;

    // One byte of the reflected CRC-16 (poly 0x8408), data LSB-first.
    function automatic logic [15:0] f_crc_byte(
        input logic [15:0] c,
        input logic [7:0]  d
    );
        logic [15:0] x;
        x = c;
        for (int i = 0; i < 8; i++) begin
            if (x[0] ^ d[i]) x = {1'b0, x[15:1]} ^ 16'h8408;
            else             x = {1'b0, x[15:1]};
        end
        return x;
    endfunction
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state and output decode; outputs depend only on state and
    // registered data, so they hold steady while the sink stalls.
    always_comb begin
        w_next    = r_state;
        busy      = (r_state != IDLE);
        buf_rden  = 1'b0;
        byte_vld  = 1'b0;
        byte_last = 1'b0;
        byte_data = 8'h00;
        unique case (r_state)
            IDLE: begin
                if (pkt_start) begin
                    if (word_count != 16'd0) w_next = FETCH;
`ifdef CSI2TX_PAYLOAD_CRC_EN
                    else                     w_next = CRC_LO;
`endif
                end
            end
            FETCH: begin
                if (!buf_empty) begin
                    buf_rden = 1'b1;
                    w_next   = WAIT;
                end
            end
            WAIT: begin
                if (buf_rddata_vld) w_next = SHIFT;
            end
            SHIFT: begin
                byte_vld  = 1'b1;
                byte_data = r_shift[7:0];
`ifndef CSI2TX_PAYLOAD_CRC_EN
                byte_last = (r_cnt == 16'd1);
`endif
                if (byte_rdy) begin
                    if (r_cnt == 16'd1) begin
`ifdef CSI2TX_PAYLOAD_CRC_EN
                        w_next = CRC_LO;
`else
                        w_next = IDLE;
`endif
                    end else if (r_idx == 2'd3) begin
                        w_next = FETCH;
                    end
                end
            end
`ifdef CSI2TX_PAYLOAD_CRC_EN
            CRC_LO: begin
                byte_vld  = 1'b1;
                byte_data = r_crc[7:0];
                if (byte_rdy) w_next = CRC_HI;
            end
            CRC_HI: begin
                byte_vld  = 1'b1;
                byte_last = 1'b1;
                byte_data = r_crc[15:8];
                if (byte_rdy) w_next = IDLE;
            end
`endif
            default: w_next = IDLE;
        endcase
    end

    // Byte counter and word shift register; bytes leave from the bottom.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= 16'd0;
            r_shift <= 32'd0;
            r_idx   <= 2'd0;
        end else begin
            if (w_start)    r_cnt <= word_count;
            else if (w_adv) r_cnt <= r_cnt - 16'd1;
            if (w_load) begin
                r_shift <= buf_rddata;
                r_idx   <= 2'd0;
            end else if (w_adv) begin
                r_shift <= {8'h00, r_shift[31:8]};
                r_idx   <= r_idx + 2'd1;
            end
        end
    end

`ifdef CSI2TX_PAYLOAD_CRC_EN
    // Running CRC over transferred payload bytes; result latched at packet end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_crc     <= CRC_SEED;
            r_crc_out <= 16'd0;
        end else begin
            if (w_start)    r_crc <= CRC_SEED;
            else if (w_adv) r_crc <= f_crc_byte(r_crc, r_shift[7:0]);
            if ((r_state == CRC_HI) && byte_rdy) r_crc_out <= r_crc;
        end
    end

    assign crc_out = r_crc_out;
`else
    logic [15:0] w_unused_seed;
    assign w_unused_seed = CRC_SEED;
    assign crc_out       = 16'd0;
`endif

endmodule

// File: tb/tb_csi2tx_payload_serializer.sv
// Self-checking bench for csi2tx_payload_serializer (scoreboard on byte stream).
// Expectations follow CSI2TX_PAYLOAD_CRC_EN as defined for the build.
module tb_csi2tx_payload_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        pkt_start;
    logic [15:0] word_count;
    logic        busy;
    logic        buf_rden;
    logic [31:0] buf_rddata;
    logic        buf_rddata_vld;
    logic        buf_empty;
    logic [7:0]  byte_data;
    logic        byte_vld;
    logic        byte_rdy;
    logic        byte_last;
    logic [15:0] crc_out;

    int          total = 0;
    int          bad = 0;
    int          rden_count = 0;
    int          n_bytes = 0;
    int          n_stall = 0;
    bit          force_empty = 1'b0;
    bit          toggle_rdy = 1'b0;
    logic [8:0]  exp_q[$];
    logic [31:0] mem[$];
    logic [31:0] cur_words[$];
    logic [15:0] exp_crc;

    csi2tx_payload_serializer #(.CRC_SEED(16'hFFFF)) dut (
        .clk            (clk),
        .rst            (rst),
        .pkt_start      (pkt_start),
        .word_count     (word_count),
        .busy           (busy),
        .buf_rden       (buf_rden),
        .buf_rddata     (buf_rddata),
        .buf_rddata_vld (buf_rddata_vld),
        .buf_empty      (buf_empty),
        .byte_data      (byte_data),
        .byte_vld       (byte_vld),
        .byte_rdy       (byte_rdy),
        .byte_last      (byte_last),
        .crc_out        (crc_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [15:0] crc_step(input logic [15:0] c,
                                             input logic [7:0] d);
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) c = {1'b0, c[15:1]} ^ 16'h8408;
            else             c = {1'b0, c[15:1]};
        end
        return c;
    endfunction

    // Load cur_words into the buffer and push the expected byte stream.
    task automatic prep(input int wc);
        logic [15:0] c;
        logic [31:0] w;
        logic [7:0]  b;
        int          n;
        c = 16'hFFFF;
        n = 0;
        foreach (cur_words[k]) begin
            w = cur_words[k];
            mem.push_back(w);
            for (int j = 0; j < 4; j++) begin
                if (n < wc) begin
                    b = w[8*j +: 8];
`ifdef CSI2TX_PAYLOAD_CRC_EN
                    exp_q.push_back({1'b0, b});
`else
                    exp_q.push_back({(n == wc - 1), b});
`endif
                    c = crc_step(c, b);
                    n++;
                end
            end
        end
`ifdef CSI2TX_PAYLOAD_CRC_EN
        exp_q.push_back({1'b0, c[7:0]});
        exp_q.push_back({1'b1, c[15:8]});
        exp_crc = c;
`else
        exp_crc = 16'd0;
`endif
    endtask

    task automatic start_pkt(input logic [15:0] wc);
        word_count = wc;
        pkt_start  = 1'b1;
        @(posedge clk); #1;
        pkt_start  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_bytes(input int n, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (n_bytes >= n) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, {31'd0, ok}, 32'd1);
    endtask

    task automatic load_vec40();
        cur_words = '{32'h020000FF, 32'h72F3DCB9, 32'h5AB8D4BB,
                      32'h7CC275C8, 32'hDF05F881, 32'h010000FF};
    endtask

    // Buffer model and sink-ready driver.
    initial forever begin
        bit seen;
        @(negedge clk);
        seen = buf_rden;
        if (buf_rden) begin
            rden_count++;
            chk("rden_while_empty", {31'd0, buf_empty}, 32'd0);
        end
        @(posedge clk); #1;
        if (seen && mem.size() > 0) begin
            buf_rddata     = mem.pop_front();
            buf_rddata_vld = 1'b1;
        end else begin
            buf_rddata_vld = 1'b0;
        end
        buf_empty = force_empty || (mem.size() == 0);
        byte_rdy  = toggle_rdy ? ~byte_rdy : 1'b1;
    end

    // Byte monitor: scoreboard pop on transfer, hold check on stall.
    initial begin
        logic [7:0] p_data;
        logic       p_vld;
        logic       p_last;
        bit         p_stall;
        logic [8:0] e;
        p_stall = 1'b0;
        p_data  = 8'h00;
        p_vld   = 1'b0;
        p_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                p_stall = 1'b0;
            end else begin
                if (p_stall) begin
                    n_stall++;
                    chk("hold_data", {24'd0, byte_data}, {24'd0, p_data});
                    chk("hold_vld", {31'd0, byte_vld}, {31'd0, p_vld});
                    chk("hold_last", {31'd0, byte_last}, {31'd0, p_last});
                end
                if (byte_vld && byte_rdy) begin
                    n_bytes++;
                    chk("byte_expected", {31'd0, exp_q.size() > 0}, 32'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("byte", {23'd0, byte_last, byte_data}, {23'd0, e});
                    end
                end
                p_stall = byte_vld && !byte_rdy;
                p_data  = byte_data;
                p_vld   = byte_vld;
                p_last  = byte_last;
            end
        end
    end

    initial begin
        int busy_n;
        rst            = 1'b1;
        pkt_start      = 1'b0;
        word_count     = 16'd0;
        byte_rdy       = 1'b1;
        buf_rddata     = 32'd0;
        buf_rddata_vld = 1'b0;
        buf_empty      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rden", {31'd0, buf_rden}, 32'd0);
        chk("rst_vld", {31'd0, byte_vld}, 32'd0);
        chk("rst_last", {31'd0, byte_last}, 32'd0);
        chk("rst_data", {24'd0, byte_data}, 32'd0);
        chk("rst_crc", {16'd0, crc_out}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Full CRC vector, sink always ready.
        rden_count = 0;
        load_vec40();
        prep(24);
        start_pkt(16'd24);
        wait_done("vec_done");
`ifdef CSI2TX_PAYLOAD_CRC_EN
        chk("vec_crc", {16'd0, crc_out}, 32'h000000F0);
`else
        chk("vec_crc", {16'd0, crc_out}, 32'd0);
`endif
        chk("vec_rden", rden_count, 32'd6);

        // Partial last word.
        rden_count = 0;
        cur_words  = '{32'h44332211, 32'h88776655};
        prep(5);
        start_pkt(16'd5);
        wait_done("part_done");
        chk("part_crc", {16'd0, crc_out}, {16'd0, exp_crc});
        chk("part_rden", rden_count, 32'd2);

        // Zero length.
        rden_count = 0;
        cur_words.delete();
        prep(0);
        start_pkt(16'd0);
        busy_n = 0;
        for (int i = 0; i < 6; i++) begin
            if (busy) busy_n++;
            @(posedge clk); #1;
        end
        wait_done("zero_done");
        chk("zero_rden", rden_count, 32'd0);
`ifdef CSI2TX_PAYLOAD_CRC_EN
        chk("zero_crc", {16'd0, crc_out}, 32'h0000FFFF);
`else
        chk("zero_busy", {31'd0, busy_n <= 2}, 32'd1);
        chk("zero_crc", {16'd0, crc_out}, 32'd0);
`endif

        // Backpressure plus empty buffer mid-packet.
        rden_count = 0;
        n_bytes    = 0;
        n_stall    = 0;
        toggle_rdy = 1'b1;
        load_vec40();
        prep(24);
        start_pkt(16'd24);
        wait_bytes(6, "bp_progress");
        force_empty = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
        end
        force_empty = 1'b0;
        wait_done("bp_done");
        toggle_rdy = 1'b0;
`ifdef CSI2TX_PAYLOAD_CRC_EN
        chk("bp_crc", {16'd0, crc_out}, 32'h000000F0);
`endif
        chk("bp_rden", rden_count, 32'd6);
        chk("bp_stalls", {31'd0, n_stall > 0}, 32'd1);

        // Reset after byte 7.
        n_bytes = 0;
        load_vec40();
        prep(24);
        start_pkt(16'd24);
        wait_bytes(7, "mid_progress");
        rst = 1'b1;
        exp_q.delete();
        mem.delete();
        @(negedge clk);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_rden", {31'd0, buf_rden}, 32'd0);
        chk("mid_vld", {31'd0, byte_vld}, 32'd0);
        chk("mid_last", {31'd0, byte_last}, 32'd0);
        chk("mid_data", {24'd0, byte_data}, 32'd0);
        chk("mid_crc", {16'd0, crc_out}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mem.push_back(32'hDEADBEEF);
        rden_count = 0;
        repeat (8) begin
            @(posedge clk); #1;
        end
        chk("post_rst_rden", rden_count, 32'd0);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        mem.delete();
        @(posedge clk); #1;

        // Recovery packet with an ignored pkt_start while busy.
        rden_count = 0;
        load_vec40();
        prep(24);
        start_pkt(16'd24);
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("rec_busy", {31'd0, busy}, 32'd1);
        start_pkt(16'd8);
        wait_done("rec_done");
`ifdef CSI2TX_PAYLOAD_CRC_EN
        chk("rec_crc", {16'd0, crc_out}, 32'h000000F0);
`else
        chk("rec_crc", {16'd0, crc_out}, 32'd0);
`endif
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("rec_rden", rden_count, 32'd6);
        chk("rec_idle", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
